os_rx_parser: RTL and testbench
===============================

Name: os_rx_parser

Overview:
- MAC-side receive parser for the PHY-to-MAC symbol stream; it is the consumer of the rxdata/rxdatak/rxvalid stream that the PHY receive driver produces.
- Aligns on COM and classifies TS1, TS2 and SKP ordered sets.
- Extracts the TS header fields and counts consecutive identical TS sets for LTSSM exit conditions (e.g. 8 consecutive TS1).
- Sits between the phy2macdriver interface and the MAC LTSSM.

Parameters:
- SKP_LEN, 3: number of SKP symbols following COM in a SKP ordered set.
- CONSEC_MAX, 8: saturation value of consec_cnt.
- CNT_W, $clog2(CONSEC_MAX+1): width of consec_cnt.

Ports:
- clk  in  1  symbol clock.
- p2md_rstn  in  1  asynchronous active-low reset.
- en_n  in  1  active-high synchronous disable; when high, the parser is held in its reset state.
- rxdata  in  8  received symbol.
- rxdatak  in  1  1 = K symbol (COM 0xBC, SKP 0x1C, PAD 0xF7).
- rxvalid  in  1  symbol qualifier.
- os_valid  out  1  one-cycle pulse: a complete ordered set was received.
- os_type  out  2  0 none, 1 TS1, 2 TS2, 3 SKP.
- link_num  out  8  TS symbol 1 (0xF7 if PAD).
- lane_num  out  8  TS symbol 2 (0xF7 if PAD).
- link_pad, lane_pad  out  1 each  field was K PAD.
- n_fts  out  8  TS symbol 3.
- rate_id  out  8  TS symbol 4.
- train_ctrl  out  8  TS symbol 5.
- consec_cnt  out  CNT_W  consecutive identical TS count.
- os_err  out  1  one-cycle pulse on a malformed ordered set.

Behaviour:
- Reset (async, p2md_rstn low) or en_n high at a clock edge:
  - All outputs are 0 and the FSM is in HUNT.
  - Symbol index, shadow fields and ident register are cleared.
- rxvalid = 0: the symbol is ignored and all state is held. Pulses still deassert after one cycle.
- FSM states: HUNT, HDR, IDENT, SKP.
- HUNT:
  - K COM -> HDR, idx = 1.
  - Any other symbol is discarded without error.
- HDR, idx 1:
  - K SKP -> SKP state, skp_cnt = 1.
  - D, or K PAD -> capture link shadow and link_pad.
  - Anything else -> error.
- HDR, idx 2: D, or K PAD -> capture lane shadow and lane_pad; otherwise error.
- HDR, idx 3..5: must be D. Captures n_fts, rate_id, train_ctrl. Any K -> error.
  - After idx 5 -> IDENT, idx = 6.
- IDENT, idx 6:
  - D 0x4A -> ident = TS1; D 0x45 -> ident = TS2.
  - Anything else -> error.
- IDENT, idx 7..15: symbol must equal the idx-6 identifier, otherwise error.
  - idx 15 accepted -> complete TS, return to HUNT.
- SKP state:
  - Each K SKP increments skp_cnt.
  - skp_cnt reaching SKP_LEN -> complete SKP, return to HUNT.
  - Any non-SKP symbol first -> error.
- COM received in HDR, IDENT or SKP: os_err pulses and the FSM resyncs, i.e. the COM is treated as a new start (HDR, idx = 1).
- Other error: os_err pulses the next cycle, FSM -> HUNT, consec_cnt cleared to 0.
- Completion timing: os_valid pulses for exactly one cycle, registered, in the cycle after the last symbol is sampled.
- On a TS completion, os_type, link_num, lane_num, link_pad, lane_pad, n_fts, rate_id and train_ctrl update in the same cycle as os_valid.
- On a SKP completion, only os_type updates (to 3); TS fields hold.
- All output fields hold their values until the next completion.
- consec_cnt, on TS completion:
  - Same type and all five fields plus pad flags equal the previous TS -> consec_cnt = min(consec_cnt+1, CONSEC_MAX).
  - Otherwise consec_cnt = 1.
  - SKP completion leaves consec_cnt unchanged.
- os_valid and os_err are never asserted in the same cycle.

Test Plan:
- 8 back-to-back identical TS1 (COM, link 0x00, lane 0x00, N_FTS 0x10, rate 0x02, ctrl 0x00, 10×0x4A) -> 8 os_valid pulses, os_type = 1, consec_cnt 1..8; a 9th TS1 holds consec_cnt at 8; no os_err.
- TS1 with link and lane as K PAD, then TS2 (10×0x45) -> first: link_num = 0xF7, link_pad = lane_pad = 1, consec_cnt = 1; TS2: os_type = 2, consec_cnt = 1.
- COM + 3×SKP between two identical TS1 -> SKP yields os_type = 3 with no os_err; consec_cnt goes 1 -> 1 -> 2.
- TS1 with 0x45 at idx 9 -> os_err pulse, no os_valid, consec_cnt = 0; the following good TS1 gives consec_cnt = 1.
- COM at idx 10 followed by a full TS2 -> one os_err pulse, then os_valid with os_type = 2.
- rxvalid low for 3 cycles mid-TS1; separately, p2md_rstn low mid-TS1 -> with rxvalid gaps the TS1 still completes with correct fields; after the reset all outputs are 0 and a partial tail yields nothing until the next COM.

Source files
------------

// File: rtl/os_rx_parser.sv
// Receive-side ordered-set parser: aligns on COM, classifies TS1/TS2/SKP,
// extracts TS header fields and counts consecutive identical TS sets.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_HUNT  | waiting for COM, everything else discarded silently
// ST_HDR   | TS symbols 1..5 (link, lane, n_fts, rate, ctrl) or SKP entry
// ST_IDENT | TS symbols 6..15, all must carry the same TS1/TS2 identifier
// ST_SKP   | counting SKP symbols until SKP_LEN have been seen
module os_rx_parser #(
    parameter int SKP_LEN    = 3,
    parameter int CONSEC_MAX = 8,
    parameter int CNT_W      = $clog2(CONSEC_MAX + 1)
) (
    input  logic             clk,
    input  logic             p2md_rstn,
    input  logic             en_n,
    input  logic [7:0]       rxdata,
    input  logic             rxdatak,
    input  logic             rxvalid,
    output logic             os_valid,
    output logic [1:0]       os_type,
    output logic [7:0]       link_num,
    output logic [7:0]       lane_num,
    output logic             link_pad,
    output logic             lane_pad,
    output logic [7:0]       n_fts,
    output logic [7:0]       rate_id,
    output logic [7:0]       train_ctrl,
    output logic [CNT_W-1:0] consec_cnt,
    output logic             os_err
);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] D_TS1 = 8'h4A;
    localparam logic [7:0] D_TS2 = 8'h45;
    localparam int SKW = (SKP_LEN > 1) ? $clog2(SKP_LEN + 1) : 1;
    localparam logic [SKW-1:0]   SKP_LAST   = SKW'(SKP_LEN - 1);
    localparam logic [CNT_W-1:0] CONSEC_SAT = CNT_W'(CONSEC_MAX);

    typedef enum logic [1:0] {ST_HUNT, ST_HDR, ST_IDENT, ST_SKP} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [SKW-1:0]   skp_cnt;
    logic [1:0]       ident;
    logic [1:0]       prev_type;
    logic [7:0]       sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl;
    logic             sh_link_pad, sh_lane_pad;

    logic             is_d, is_com, is_skp, is_pad, sym_bad, same_ts;
    logic [7:0]       ident_byte;
    logic [CNT_W-1:0] consec_next;

    assign is_d       = ~rxdatak;
    assign is_com     = rxdatak && (rxdata == K_COM);
    assign is_skp     = rxdatak && (rxdata == K_SKP);
    assign is_pad     = rxdatak && (rxdata == K_PAD);
    assign ident_byte = (ident == 2'd1) ? D_TS1 : D_TS2;

    // The output registers always hold the last completed TS, so they double
    // as the reference for the identical-TS comparison.
    assign same_ts = (prev_type == ident) && (link_num == sh_link) &&
                     (lane_num == sh_lane) && (link_pad == sh_link_pad) &&
                     (lane_pad == sh_lane_pad) && (n_fts == sh_nfts) &&
                     (rate_id == sh_rate) && (train_ctrl == sh_ctrl);
    assign consec_next = !same_ts ? CNT_W'(1) :
                         (consec_cnt == CONSEC_SAT) ? CONSEC_SAT : consec_cnt + 1'b1;

    always_comb begin
        sym_bad = 1'b0;
        case (state)
            ST_HDR: begin
                if (idx <= 4'd2)
                    sym_bad = !(is_d || is_pad) && !((idx == 4'd1) && is_skp);
                else
                    sym_bad = !is_d;
            end
            ST_IDENT: begin
                if (idx == 4'd6)
                    sym_bad = !(is_d && ((rxdata == D_TS1) || (rxdata == D_TS2)));
                else
                    sym_bad = !(is_d && (rxdata == ident_byte));
            end
            ST_SKP:  sym_bad = !is_skp;
            default: sym_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge p2md_rstn) begin
        if (!p2md_rstn) begin
            state <= ST_HUNT;   idx <= '0;        skp_cnt <= '0;
            ident <= '0;        prev_type <= '0;
            sh_link <= '0;      sh_lane <= '0;    sh_nfts <= '0;
            sh_rate <= '0;      sh_ctrl <= '0;
            sh_link_pad <= 1'b0; sh_lane_pad <= 1'b0;
            os_valid <= 1'b0;   os_err <= 1'b0;   os_type <= '0;
            link_num <= '0;     lane_num <= '0;   link_pad <= 1'b0;
            lane_pad <= 1'b0;   n_fts <= '0;      rate_id <= '0;
            train_ctrl <= '0;   consec_cnt <= '0;
        end else if (en_n) begin
            state <= ST_HUNT;   idx <= '0;        skp_cnt <= '0;
            ident <= '0;        prev_type <= '0;
            sh_link <= '0;      sh_lane <= '0;    sh_nfts <= '0;
            sh_rate <= '0;      sh_ctrl <= '0;
            sh_link_pad <= 1'b0; sh_lane_pad <= 1'b0;
            os_valid <= 1'b0;   os_err <= 1'b0;   os_type <= '0;
            link_num <= '0;     lane_num <= '0;   link_pad <= 1'b0;
            lane_pad <= 1'b0;   n_fts <= '0;      rate_id <= '0;
            train_ctrl <= '0;   consec_cnt <= '0;
        end else begin
            os_valid <= 1'b0;
            os_err   <= 1'b0;
            if (rxvalid) begin
                if (is_com && (state != ST_HUNT)) begin
                    os_err <= 1'b1;
                    state  <= ST_HDR;
                    idx    <= 4'd1;
                end else if (sym_bad) begin
                    os_err     <= 1'b1;
                    state      <= ST_HUNT;
                    idx        <= '0;
                    consec_cnt <= '0;
                end else begin
                    case (state)
                        ST_HUNT: begin
                            if (is_com) begin
                                state <= ST_HDR;
                                idx   <= 4'd1;
                            end
                        end
                        ST_HDR: begin
                            if ((idx == 4'd1) && is_skp) begin
                                if (SKP_LEN <= 1) begin
                                    os_valid <= 1'b1;
                                    os_type  <= 2'd3;
                                    state    <= ST_HUNT;
                                    idx      <= '0;
                                end else begin
                                    state   <= ST_SKP;
                                    skp_cnt <= SKW'(1);
                                end
                            end else begin
                                case (idx)
                                    4'd1: begin sh_link <= rxdata; sh_link_pad <= rxdatak; end
                                    4'd2: begin sh_lane <= rxdata; sh_lane_pad <= rxdatak; end
                                    4'd3: sh_nfts <= rxdata;
                                    4'd4: sh_rate <= rxdata;
                                    default: sh_ctrl <= rxdata;
                                endcase
                                if (idx == 4'd5) state <= ST_IDENT;
                                idx <= idx + 4'd1;
                            end
                        end
                        ST_IDENT: begin
                            if (idx == 4'd6) begin
                                ident <= (rxdata == D_TS1) ? 2'd1 : 2'd2;
                                idx   <= idx + 4'd1;
                            end else if (idx == 4'd15) begin
                                os_valid   <= 1'b1;
                                os_type    <= ident;
                                link_num   <= sh_link;
                                lane_num   <= sh_lane;
                                link_pad   <= sh_link_pad;
                                lane_pad   <= sh_lane_pad;
                                n_fts      <= sh_nfts;
                                rate_id    <= sh_rate;
                                train_ctrl <= sh_ctrl;
                                prev_type  <= ident;
                                consec_cnt <= consec_next;
                                state      <= ST_HUNT;
                                idx        <= '0;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                        ST_SKP: begin
                            if (skp_cnt == SKP_LAST) begin
                                os_valid <= 1'b1;
                                os_type  <= 2'd3;
                                state    <= ST_HUNT;
                                idx      <= '0;
                            end else begin
                                skp_cnt <= skp_cnt + 1'b1;
                            end
                        end
                        default: state <= ST_HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_os_rx_parser.sv
// Bench for os_rx_parser: directed scenarios plus a random ordered-set stream,
// checked against a symbol-buffer reference model.
module tb_os_rx_parser;
    localparam int SKP_LEN = 3;
    localparam int CONSEC_MAX = 8;
    localparam int CNT_W = 4;
    localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, PAD = 8'hF7;
    localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45;

    logic clk = 1'b0, p2md_rstn = 1'b0, en_n = 1'b0;
    logic [7:0] rxdata = '0;
    logic rxdatak = 1'b0, rxvalid = 1'b0;
    logic os_valid, os_err, link_pad, lane_pad;
    logic [1:0] os_type;
    logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctrl;
    logic [CNT_W-1:0] consec_cnt;

    os_rx_parser #(.SKP_LEN(SKP_LEN), .CONSEC_MAX(CONSEC_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .p2md_rstn(p2md_rstn), .en_n(en_n), .rxdata(rxdata),
        .rxdatak(rxdatak), .rxvalid(rxvalid), .os_valid(os_valid), .os_type(os_type),
        .link_num(link_num), .lane_num(lane_num), .link_pad(link_pad),
        .lane_pad(lane_pad), .n_fts(n_fts), .rate_id(rate_id),
        .train_ctrl(train_ctrl), .consec_cnt(consec_cnt), .os_err(os_err));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // reference model: buffer of symbols since the last COM
    logic [8:0] q[$];
    bit         in_set;
    logic       m_valid, m_err, m_lpad, m_npad, p_lpad, p_npad;
    logic [1:0] m_type, p_type;
    logic [7:0] m_link, m_lane, m_nfts, m_rate, m_ctrl;
    logic [7:0] p_link, p_lane, p_nfts, p_rate, p_ctrl;
    logic [3:0] m_consec;

    logic [49:0] obs;
    assign obs = {os_valid, os_err, os_type, link_num, lane_num, link_pad, lane_pad,
                  n_fts, rate_id, train_ctrl, consec_cnt};

    function automatic logic [49:0] exp_vec();
        return {m_valid, m_err, m_type, m_link, m_lane, m_lpad, m_npad,
                m_nfts, m_rate, m_ctrl, m_consec};
    endfunction

    task automatic model_reset();
        q.delete(); in_set = 0;
        m_valid = 0; m_err = 0; m_type = 0; m_link = 0; m_lane = 0; m_lpad = 0;
        m_npad = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0; m_consec = 0;
        p_type = 0; p_link = 0; p_lane = 0; p_lpad = 0; p_npad = 0;
        p_nfts = 0; p_rate = 0; p_ctrl = 0;
    endtask

    // 0 partial, 1 complete TS, 2 complete SKP, 3 malformed
    function automatic int classify();
        int n = q.size();
        if (q[0] == {1'b1, SKP}) begin
            foreach (q[i]) if (q[i] != {1'b1, SKP}) return 3;
            return (n == SKP_LEN) ? 2 : 0;
        end
        for (int i = 0; i < n; i++) begin
            int pos = i + 1;
            logic k = q[i][8];
            logic [7:0] d = q[i][7:0];
            if (pos <= 2) begin
                if (k && d != PAD) return 3;
            end else if (pos <= 5) begin
                if (k) return 3;
            end else if (pos == 6) begin
                if (k || (d != TS1 && d != TS2)) return 3;
            end else if (k || d != q[5][7:0]) begin
                return 3;
            end
        end
        return (n == 15) ? 1 : 0;
    endfunction

    task automatic model_step(input logic k, input logic [7:0] d, input logic v);
        logic [1:0] ty;
        bit same;
        m_valid = 0; m_err = 0;
        if (en_n) begin model_reset(); return; end
        if (!v) return;
        if (k && d == COM) begin
            if (in_set) m_err = 1;
            in_set = 1; q.delete();
            return;
        end
        if (!in_set) return;
        q.push_back({k, d});
        case (classify())
            1: begin
                ty = (q[5][7:0] == TS1) ? 2'd1 : 2'd2;
                same = (ty == p_type) && (q[0] == {p_lpad, p_link}) && (q[1] == {p_npad, p_lane})
                       && (q[2][7:0] == p_nfts) && (q[3][7:0] == p_rate) && (q[4][7:0] == p_ctrl);
                m_consec = !same ? 4'd1 : (m_consec >= CONSEC_MAX) ? 4'(CONSEC_MAX) : m_consec + 4'd1;
                m_valid = 1; m_type = ty;
                {m_lpad, m_link} = q[0]; {m_npad, m_lane} = q[1];
                m_nfts = q[2][7:0]; m_rate = q[3][7:0]; m_ctrl = q[4][7:0];
                p_type = ty; {p_lpad, p_link} = q[0]; {p_npad, p_lane} = q[1];
                p_nfts = m_nfts; p_rate = m_rate; p_ctrl = m_ctrl;
                in_set = 0;
            end
            2: begin m_valid = 1; m_type = 3; in_set = 0; end
            3: begin m_err = 1; m_consec = 0; in_set = 0; end
            default: ;
        endcase
    endtask

    // stimulus queue entries are {rxvalid, rxdatak, rxdata}
    logic [9:0] sq[$];
    int nv, ne, vi;

    task automatic push_ts(input logic [7:0] idb, input logic [7:0] link, input logic lpad,
                           input logic [7:0] lane, input logic npad, input logic [7:0] nfts,
                           input logic [7:0] rate, input logic [7:0] ctrl);
        sq.push_back({2'b11, COM});
        sq.push_back({1'b1, lpad, lpad ? PAD : link});
        sq.push_back({1'b1, npad, npad ? PAD : lane});
        sq.push_back({2'b10, nfts});
        sq.push_back({2'b10, rate});
        sq.push_back({2'b10, ctrl});
        repeat (10) sq.push_back({2'b10, idb});
    endtask

    task automatic push_skp();
        sq.push_back({2'b11, COM});
        repeat (SKP_LEN) sq.push_back({2'b11, SKP});
    endtask

    task automatic drive(input logic [9:0] s);
        {rxvalid, rxdatak, rxdata} = s;
        @(posedge clk);
        model_step(s[8], s[7:0], s[9]);
        #1;
    endtask

    task automatic test_reset();
        p2md_rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        total++;
        if (obs !== 50'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
        p2md_rstn = 1;
        drive({2'b10, TS1});
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL hunt_discard: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_consec();
        sq.delete(); nv = 0; ne = 0; vi = 0;
        repeat (9) push_ts(TS1, 8'h00, 0, 8'h00, 0, 8'h10, 8'h02, 8'h00);
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL consec_step: got %h want %h", obs, exp_vec()); end
            nv += int'(os_valid); ne += int'(os_err);
            if (os_valid) begin
                vi++;
                total++;
                if (consec_cnt !== 4'((vi > 8) ? 8 : vi) || os_type !== 2'd1) begin
                    bad++; $display("FAIL consec_value: got cnt=%0d type=%0d want cnt=%0d type=1",
                                    consec_cnt, os_type, (vi > 8) ? 8 : vi);
                end
            end
        end
        total++;
        if (nv != 9 || ne != 0) begin bad++; $display("FAIL consec_pulses: got valid=%0d err=%0d want 9/0", nv, ne); end
    endtask

    task automatic test_pad_ts2();
        sq.delete(); nv = 0;
        push_ts(TS1, 8'h00, 1, 8'h00, 1, 8'h10, 8'h02, 8'h00);
        push_ts(TS2, 8'h00, 0, 8'h00, 0, 8'h10, 8'h02, 8'h00);
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL pad_step: got %h want %h", obs, exp_vec()); end
            if (os_valid) begin
                nv++;
                total++;
                if (nv == 1 && {link_num, lane_num, link_pad, lane_pad, consec_cnt} !== {8'hF7, 8'hF7, 2'b11, 4'd1}) begin
                    bad++; $display("FAIL pad_fields: got link=%h lane=%h pads=%b%b cnt=%0d want f7 f7 11 1",
                                    link_num, lane_num, link_pad, lane_pad, consec_cnt);
                end
                if (nv == 2 && {os_type, consec_cnt, link_pad} !== {2'd2, 4'd1, 1'b0}) begin
                    bad++; $display("FAIL ts2_fields: got type=%0d cnt=%0d pad=%b want 2 1 0", os_type, consec_cnt, link_pad);
                end
            end
        end
    endtask

    task automatic test_skp();
        sq.delete(); nv = 0; ne = 0;
        push_ts(TS1, 8'h05, 0, 8'h01, 0, 8'h20, 8'h02, 8'h00);
        push_skp();
        push_ts(TS1, 8'h05, 0, 8'h01, 0, 8'h20, 8'h02, 8'h00);
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL skp_step: got %h want %h", obs, exp_vec()); end
            nv += int'(os_valid); ne += int'(os_err);
            if (os_valid && nv == 2) begin
                total++;
                if (os_type !== 2'd3 || consec_cnt !== 4'd1 || link_num !== 8'h05) begin
                    bad++; $display("FAIL skp_type: got type=%0d cnt=%0d link=%h want 3 1 05", os_type, consec_cnt, link_num);
                end
            end
        end
        total++;
        if (nv != 3 || ne != 0 || consec_cnt !== 4'd2) begin
            bad++; $display("FAIL skp_summary: got valid=%0d err=%0d cnt=%0d want 3 0 2", nv, ne, consec_cnt);
        end
    endtask

    task automatic test_bad_ident();
        sq.delete(); nv = 0; ne = 0;
        push_ts(TS1, 8'h05, 0, 8'h01, 0, 8'h20, 8'h02, 8'h00);
        sq[9] = {2'b10, TS2};
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL badid_step: got %h want %h", obs, exp_vec()); end
            nv += int'(os_valid); ne += int'(os_err);
        end
        total++;
        if (nv != 0 || ne != 1 || consec_cnt !== 4'd0) begin
            bad++; $display("FAIL badid_summary: got valid=%0d err=%0d cnt=%0d want 0 1 0", nv, ne, consec_cnt);
        end
        push_ts(TS1, 8'h05, 0, 8'h01, 0, 8'h20, 8'h02, 8'h00);
        while (sq.size() > 0) drive(sq.pop_front());
        total++;
        if (os_valid !== 1'b1 || consec_cnt !== 4'd1) begin
            bad++; $display("FAIL badid_recover: got valid=%b cnt=%0d want 1 1", os_valid, consec_cnt);
        end
    endtask

    task automatic test_com_resync();
        sq.delete(); nv = 0; ne = 0;
        push_ts(TS1, 8'h03, 0, 8'h02, 0, 8'h11, 8'h01, 8'h04);
        repeat (6) void'(sq.pop_back());
        push_ts(TS2, 8'h03, 0, 8'h02, 0, 8'h11, 8'h01, 8'h04);
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL resync_step: got %h want %h", obs, exp_vec()); end
            nv += int'(os_valid); ne += int'(os_err);
        end
        total++;
        if (nv != 1 || ne != 1 || os_type !== 2'd2) begin
            bad++; $display("FAIL resync_summary: got valid=%0d err=%0d type=%0d want 1 1 2", nv, ne, os_type);
        end
    endtask

    task automatic test_gaps_and_reset();
        sq.delete(); nv = 0; ne = 0;
        push_ts(TS1, 8'h07, 0, 8'h09, 0, 8'h33, 8'h01, 8'h08);
        for (int i = 0; i < 3; i++) sq.insert(7, {2'b00, 8'(SKP + i)});
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL gap_step: got %h want %h", obs, exp_vec()); end
            nv += int'(os_valid);
        end
        total++;
        if (nv != 1 || n_fts !== 8'h33 || lane_num !== 8'h09) begin
            bad++; $display("FAIL gap_summary: got valid=%0d nfts=%h lane=%h want 1 33 09", nv, n_fts, lane_num);
        end
        push_ts(TS1, 8'h07, 0, 8'h09, 0, 8'h33, 8'h01, 8'h08);
        repeat (8) drive(sq.pop_front());
        p2md_rstn = 0;
        #2;
        model_reset();
        total++;
        if (obs !== 50'd0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", obs); end
        @(posedge clk); #1;
        p2md_rstn = 1;
        nv = 0; ne = 0;
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            nv += int'(os_valid); ne += int'(os_err);
        end
        total++;
        if (nv != 0 || ne != 0 || obs !== 50'd0) begin
            bad++; $display("FAIL midreset_tail: got valid=%0d err=%0d obs=%h want 0 0 0", nv, ne, obs);
        end
    endtask

    task automatic test_enable();
        sq.delete();
        push_ts(TS2, 8'h01, 0, 8'h01, 0, 8'h01, 8'h01, 8'h01);
        while (sq.size() > 0) drive(sq.pop_front());
        push_ts(TS2, 8'h01, 0, 8'h01, 0, 8'h01, 8'h01, 8'h01);
        repeat (5) drive(sq.pop_front());
        en_n = 1;
        repeat (2) drive(sq.pop_front());
        en_n = 0;
        total++;
        if (obs !== 50'd0) begin bad++; $display("FAIL enable_clear: got %h want 0", obs); end
        while (sq.size() > 0) begin
            drive(sq.pop_front());
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL enable_step: got %h want %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        logic [7:0] link, lane, nfts, rate, ctrl, idb;
        logic lpad, npad;
        link = 0; lane = 0; nfts = 0; rate = 0; ctrl = 0; idb = TS1; lpad = 0; npad = 0;
        sq.delete();
        for (int it = 0; it < 160; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind <= 5 || kind >= 8) begin
                if ($urandom_range(0, 2) == 0) begin
                    lpad = ($urandom_range(0, 4) == 0); npad = ($urandom_range(0, 4) == 0);
                    link = 8'($urandom_range(0, 1)); lane = 8'($urandom_range(0, 1));
                    nfts = 8'($urandom_range(0, 1)); rate = 8'($urandom_range(1, 2));
                    ctrl = 8'($urandom_range(0, 1)); idb = ($urandom_range(0, 1) == 1) ? TS1 : TS2;
                end
                push_ts(idb, link, lpad, lane, npad, nfts, rate, ctrl);
                if (kind == 8) sq[sq.size() - 16 + $urandom_range(1, 15)] = {1'b1, 1'($urandom_range(0, 1)), 8'($urandom)};
                if (kind == 9) repeat ($urandom_range(1, 14)) void'(sq.pop_back());
            end else if (kind == 6) begin
                push_skp();
                if ($urandom_range(0, 3) == 0) sq[sq.size() - $urandom_range(1, SKP_LEN)] = {2'b10, 8'($urandom)};
            end else begin
                repeat ($urandom_range(1, 4)) sq.push_back({1'b1, 1'($urandom_range(0, 1)), 8'($urandom)});
            end
            while (sq.size() > 0) begin
                if ($urandom_range(0, 7) == 0) drive({2'b0, 8'($urandom)});
                else drive(sq.pop_front());
                total++;
                if (obs !== exp_vec()) begin bad++; $display("FAIL random_step it=%0d: got %h want %h", it, obs, exp_vec()); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_consec();
        test_pad_ts2();
        test_skp();
        test_bad_ident();
        test_com_resync();
        test_gaps_and_reset();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
